// File: rtl/display_scan.sv
// -----------------------------------------------------------------------------
// display_scan
//   Multiplexed seven-segment display scanner. It snapshots a DIGITS-nibble
//   value once per frame and presents one nibble at a time on `address`,
//   which feeds the segment decoder. It lights the matching active-low digit
//   select while that nibble is shown. Between digits, all selects are held
//   dark for BLANK_CYCLES. The decoder input only changes while the display is
//   dark, so no ghosting is visible.
//
// Parameters
//   DIGITS        number of multiplexed digits (2..8)
//   DWELL_CYCLES  clock cycles each digit is lit (>=1)
//   BLANK_CYCLES  clock cycles all digits are dark between digits (>=2)
//
// Ports
//   clock       in   system clock, rising edge
//   n_reset     in   asynchronous active-low reset
//   value       in   4*DIGITS  hex digits; digit i = value[4i+3:4i]
//   enable      in   DIGITS    per-digit enable; 0 keeps the digit dark
//   address     out  4         nibble to the segment decoder (registered)
//   digit_n     out  DIGITS    active-low digit selects (registered)
//   frame_done  out  1         one-cycle pulse after the last digit's slot
// -----------------------------------------------------------------------------
module display_scan #(
  parameter int DIGITS       = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                  clock,
  input  logic                  n_reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     enable,
  output logic [3:0]            address,
  output logic [DIGITS-1:0]     digit_n,
  output logic                  frame_done
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ALL_DARK   = '1;
  localparam logic [DIGITS-1:0] SEL_ONE    = DIGITS'(1);

  typedef enum logic {
    ST_BLANK   = 1'b0,
    ST_DISPLAY = 1'b1
  } state_t;

  state_t               r_state,      w_state_nx;
  logic [CNT_W-1:0]     r_cnt,        w_cnt_nx;
  logic [IDX_W-1:0]     r_idx,        w_idx_nx;
  logic [4*DIGITS-1:0]  r_snapshot,   w_snapshot_nx;
  logic [3:0]           r_address,    w_address_nx;
  logic [DIGITS-1:0]    r_digit_n,    w_digit_n_nx;
  logic                 r_frame_done, w_frame_done_nx;

  // Nibble of the frame snapshot selected by the current digit index.
  logic [4*DIGITS-1:0]  w_shifted;
  logic [3:0]           w_nibble;
  logic [DIGITS-1:0]    w_sel;
  logic                 w_last_digit;

  assign w_shifted    = r_snapshot >> {r_idx, 2'b00};
  assign w_nibble     = w_shifted[3:0];
  assign w_sel        = SEL_ONE << r_idx;
  assign w_last_digit = (r_idx == IDX_LAST);

  // NOTE: every next-state signal gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nx      = r_state;
    w_cnt_nx        = r_cnt + 1'b1;
    w_idx_nx        = r_idx;
    w_snapshot_nx   = r_snapshot;
    w_address_nx    = r_address;
    w_digit_n_nx    = r_digit_n;
    w_frame_done_nx = 1'b0;

    case (r_state)
      ST_BLANK: begin
        // Capture the whole value once at the start of a frame, so every digit
        // of the frame comes from the same snapshot (no tearing).
        if (r_cnt == '0 && r_idx == '0) begin
          w_snapshot_nx = value;
        end
        if (r_cnt == BLANK_LAST) begin
          w_state_nx   = ST_DISPLAY;
          w_cnt_nx     = '0;
          // Address and select change together on the only edge where the
          // display is dark, and enable is sampled only here.
          w_address_nx = w_nibble;
          w_digit_n_nx = ~(w_sel & enable);
        end
      end

      ST_DISPLAY: begin
        if (r_cnt == DWELL_LAST) begin
          w_state_nx      = ST_BLANK;
          w_cnt_nx        = '0;
          w_digit_n_nx    = ALL_DARK;
          w_idx_nx        = w_last_digit ? '0 : r_idx + 1'b1;
          w_frame_done_nx = w_last_digit;
        end
      end

      default: begin
        w_state_nx = ST_BLANK;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so all registers update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_snapshot   <= '0;
      r_address    <= '0;
      r_digit_n    <= ALL_DARK;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_idx        <= w_idx_nx;
      r_snapshot   <= w_snapshot_nx;
      r_address    <= w_address_nx;
      r_digit_n    <= w_digit_n_nx;
      r_frame_done <= w_frame_done_nx;
    end
  end

  assign address    = r_address;
  assign digit_n    = r_digit_n;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan.sv
// -----------------------------------------------------------------------------
// tb_display_scan
//   Scoreboard bench for display_scan with DIGITS=4, DWELL_CYCLES=4 and
//   BLANK_CYCLES=2, giving a slot period P=6 and a frame of 24 cycles.
//   Cycle n is the interval after the n-th rising edge following reset
//   release. The driver predicts each digit slot from the timing rules
//   (slot s is lit for [s*P+BLANK, s*P+BLANK+DWELL)) and pushes the expected
//   slot or frame pulse into queues. The monitor samples at every falling edge
//   and compares the outputs against the head of those queues.
// -----------------------------------------------------------------------------
module tb_display_scan;

  localparam int DIGITS = 4;
  localparam int DWELL  = 4;
  localparam int BLANK  = 2;
  localparam int P      = BLANK + DWELL;
  localparam int FRAME  = DIGITS * P;

  logic                clock;
  logic                n_reset;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   enable;
  logic [3:0]          address;
  logic [DIGITS-1:0]   digit_n;
  logic                frame_done;

  display_scan #(
    .DIGITS       (DIGITS),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clock      (clock),
    .n_reset    (n_reset),
    .value      (value),
    .enable     (enable),
    .address    (address),
    .digit_n    (digit_n),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         start;
    logic [3:0] addr;
    logic [3:0] dn;
  } slot_t;

  slot_t slot_q[$];
  int    fd_q[$];

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc      = 0;
  bit    running  = 1'b0;
  logic [4*DIGITS-1:0] m_snap = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Predicts what the DUT does on edge cyc+1 from the inputs now being driven.
  task automatic predict();
    int e;
    int s;
    int k;
    slot_t sl;
    e = cyc + 1;
    if (e % FRAME == 1) m_snap = value;
    if (e % P == BLANK) begin
      s        = e / P;
      k        = s % DIGITS;
      sl.start = e;
      sl.addr  = m_snap[4*k +: 4];
      sl.dn    = enable[k] ? ~(4'b0001 << k) : 4'hF;
      slot_q.push_back(sl);
      if (k == DIGITS - 1) fd_q.push_back((s + 1) * P);
    end
  endtask

  // Runs n cycles; with rnd set, value and enable change randomly now and then.
  task automatic drive(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd && $urandom_range(0, 4) == 0) value  = $urandom;
      if (rnd && $urandom_range(0, 5) == 0) enable = 4'($urandom);
      predict();
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic start_scan();
    @(negedge clock);
    slot_q.delete();
    fd_q.delete();
    n_reset = 1'b1;
    cyc     = 0;
    running = 1'b1;
  endtask

  // Monitor: compares every cycle against the scoreboard heads.
  bit         m_in_slot = 1'b0;
  int         m_end     = 0;
  logic [3:0] m_addr    = '0;
  logic [3:0] m_dn      = 4'hF;

  always @(negedge clock) begin
    slot_t cur;
    bit    exp_fd;
    #2;
    if (!running) begin
      m_in_slot = 1'b0;
      m_addr    = '0;
    end else begin
      if (m_in_slot && cyc == m_end) m_in_slot = 1'b0;
      if (slot_q.size() > 0 && slot_q[0].start == cyc) begin
        cur       = slot_q.pop_front();
        m_in_slot = 1'b1;
        m_end     = cyc + DWELL;
        m_addr    = cur.addr;
        m_dn      = cur.dn;
      end
      exp_fd = 1'b0;
      if (fd_q.size() > 0 && fd_q[0] == cyc) begin
        void'(fd_q.pop_front());
        exp_fd = 1'b1;
      end
      check("digit_n",    32'(digit_n),    m_in_slot ? 32'(m_dn) : 32'hF);
      check("address",    32'(address),    32'(m_addr));
      check("frame_done", 32'(frame_done), 32'(exp_fd));
      check("one_low",    32'($countones(~digit_n) <= 1), 32'd1);
    end
  end

  initial begin
    n_reset = 1'b0;
    value   = 16'h1234;
    enable  = 4'hF;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_digit_n",    32'(digit_n),    32'hF);
    check("rst_address",    32'(address),    32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);

    // Startup frame, then a value change inside digit 1's slot (cycles 8..11).
    start_scan();
    drive(9, 1'b0);
    value = 16'hABCD;
    drive(2 * FRAME - 9, 1'b0);

    // Enable mask, then everything disabled.
    enable = 4'b0101;
    drive(2 * FRAME, 1'b0);
    enable = 4'b0000;
    drive(FRAME, 1'b0);

    // Randomised inputs.
    enable = 4'hF;
    drive(10 * FRAME, 1'b1);

    // Reset during digit 2's display window (cycles 14..17 of a frame).
    enable = 4'hF;
    drive(15, 1'b0);
    running = 1'b0;
    check("pre_rst_digit_n", 32'(digit_n), 32'hB);
    @(posedge clock);
    #3;
    n_reset = 1'b0;
    #1;
    check("async_digit_n",    32'(digit_n),    32'hF);
    check("async_address",    32'(address),    32'h0);
    check("async_frame_done", 32'(frame_done), 32'h0);
    repeat (2) @(posedge clock);
    value = 16'h5E7C;
    start_scan();
    drive(2 * FRAME + 4, 1'b0);

    running = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
